// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, error codes,
// funct3 size codes and the funct3 legality check.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // Doubleword and unsigned-word forms exist only on the 64-bit datapath.
   function automatic logic f3_legal(input logic [2:0] f3, input logic st, input logic wide);
      logic ok;
      if (st) begin
         case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_D:             ok = wide;
            default:          ok = 1'b0;
         endcase
      end else begin
         case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            F3_D, F3_WU:                    ok = wide;
            default:                        ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store strobes/data placement and alignment
// checks on the request side, lane extraction and sign/zero extension on the load side.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int WORD_SIZE = 32
) (
   input  logic                               st_is_store,
   input  logic [2:0]                         st_funct3,
   input  logic [$clog2(WORD_SIZE/8)-1:0]     st_off,
   input  logic [WORD_SIZE-1:0]               st_data,
   output logic [WORD_SIZE/8-1:0]             wstrb,
   output logic [WORD_SIZE-1:0]               wdata,
   output logic                               legal,
   output logic                               misaligned,
   input  logic [2:0]                         ld_funct3,
   input  logic [$clog2(WORD_SIZE/8)-1:0]     ld_off,
   input  logic [WORD_SIZE-1:0]               rdata,
   output logic [WORD_SIZE-1:0]               ld_word
);

   localparam int LANES = WORD_SIZE / 8;
   localparam int OFFW  = $clog2(LANES);

   logic [OFFW-1:0]      amask_s;
   int                   st_nbytes_s;
   int                   ld_nbits_s;
   logic                 sign_bit_s;
   logic [WORD_SIZE-1:0] shifted_s;

   // Store side: legality, alignment, strobes covering [off, off+size) and shifted data.
   always_comb begin
      legal      = f3_legal(st_funct3, st_is_store, WORD_SIZE == 64);
      amask_s    = OFFW'((4'b0001 << st_funct3[1:0]) - 4'b0001);
      misaligned = |(st_off & amask_s);
      case (st_funct3[1:0])
         2'd0:    st_nbytes_s = 1;
         2'd1:    st_nbytes_s = 2;
         2'd2:    st_nbytes_s = 4;
         default: st_nbytes_s = 8;
      endcase
      for (int i = 0; i < LANES; i++) begin
         wstrb[i] = st_is_store && (i >= int'(st_off)) && (i < int'(st_off) + st_nbytes_s);
      end
      wdata = st_data << {st_off, 3'b000};
   end

   // Load side: bring the addressed lanes down to bit 0, then extend above the access size.
   always_comb begin
      shifted_s = rdata >> {ld_off, 3'b000};
      case (ld_funct3[1:0])
         2'd0: begin
            ld_nbits_s = 8;
            sign_bit_s = shifted_s[7];
         end
         2'd1: begin
            ld_nbits_s = 16;
            sign_bit_s = shifted_s[15];
         end
         2'd2: begin
            ld_nbits_s = 32;
            sign_bit_s = shifted_s[31];
         end
         default: begin
            ld_nbits_s = 64;
            sign_bit_s = shifted_s[WORD_SIZE-1];
         end
      endcase
      for (int i = 0; i < WORD_SIZE; i++) begin
         ld_word[i] = (i < ld_nbits_s) ? shifted_s[i] : (~ld_funct3[2] & sign_bit_s);
      end
   end

endmodule

// File: rtl/lsu_mem_unit.sv
// Load/store unit: accepts one access per start pulse, runs a req/ack handshake
// with a timeout against word-wide memory and reports a registered result and status.
module lsu_mem_unit
   import lsu_pkg::*;
#(
   parameter int WORD_SIZE = 32,
   parameter int MAX_WAIT  = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   is_store,
   input  logic [2:0]             funct3,
   input  logic [WORD_SIZE-1:0]   addr,
   input  logic [WORD_SIZE-1:0]   store_data,
   output logic                   busy,
   output logic                   done,
   output logic [1:0]             err_code,
   output logic [WORD_SIZE-1:0]   load_data,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [WORD_SIZE-1:0]   mem_addr,
   output logic [WORD_SIZE/8-1:0] mem_wstrb,
   output logic [WORD_SIZE-1:0]   mem_wdata,
   input  logic [WORD_SIZE-1:0]   mem_rdata,
   input  logic                   mem_ack
);

   localparam int LANES = WORD_SIZE / 8;
   localparam int OFFW  = $clog2(LANES);
   localparam int WW    = $clog2(MAX_WAIT + 1);

   state_e               state_q, state_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic [1:0]           err_q, err_d;
   logic [WORD_SIZE-1:0] load_data_q, load_data_d;
   logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [LANES-1:0]     mem_wstrb_q, mem_wstrb_d;
   logic [WW-1:0]        wait_q, wait_d;
   logic [2:0]           funct3_q, funct3_d;
   logic [OFFW-1:0]      off_q, off_d;
   logic                 is_store_q, is_store_d;

   logic                 legal_s, misal_s;
   logic [LANES-1:0]     wstrb_s;
   logic [WORD_SIZE-1:0] wdata_s, ld_word_s;

   lsu_lane_align #(.WORD_SIZE(WORD_SIZE)) u_align (
      .st_is_store (is_store),
      .st_funct3   (funct3),
      .st_off      (addr[OFFW-1:0]),
      .st_data     (store_data),
      .wstrb       (wstrb_s),
      .wdata       (wdata_s),
      .legal       (legal_s),
      .misaligned  (misal_s),
      .ld_funct3   (funct3_q),
      .ld_off      (off_q),
      .rdata       (mem_rdata),
      .ld_word     (ld_word_s)
   );

   // Next-state logic; error decisions are made in the start cycle so faults finish one cycle later.
   always_comb begin
      state_d     = state_q;
      done_d      = 1'b0;
      err_d       = err_q;
      load_data_d = load_data_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wstrb_d = mem_wstrb_q;
      mem_wdata_d = mem_wdata_q;
      wait_d      = wait_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      is_store_d  = is_store_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               funct3_d   = funct3;
               off_d      = addr[OFFW-1:0];
               is_store_d = is_store;
               if (!legal_s) begin
                  state_d = S_RESP;
                  done_d  = 1'b1;
                  err_d   = ERR_ILLEGAL;
               end else if (misal_s) begin
                  state_d = S_RESP;
                  done_d  = 1'b1;
                  err_d   = ERR_MISALIGN;
               end else begin
                  state_d     = S_REQ;
                  mem_req_d   = 1'b1;
                  mem_we_d    = is_store;
                  mem_addr_d  = {addr[WORD_SIZE-1:OFFW], {OFFW{1'b0}}};
                  mem_wstrb_d = wstrb_s;
                  mem_wdata_d = wdata_s;
                  wait_d      = '0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            // An ack in the final wait cycle still counts as success.
            if (mem_ack) begin
               state_d   = S_RESP;
               done_d    = 1'b1;
               err_d     = ERR_OK;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (!is_store_q) begin
                  load_data_d = ld_word_s;
               end else begin
                  load_data_d = load_data_q;
               end
            end else if (wait_q == WW'(MAX_WAIT - 1)) begin
               state_d   = S_RESP;
               done_d    = 1'b1;
               err_d     = ERR_TIMEOUT;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end else begin
               wait_d = wait_q + WW'(1'b1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset aborts any access without a done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= ERR_OK;
         load_data_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wstrb_q <= '0;
         mem_wdata_q <= '0;
         wait_q      <= '0;
         funct3_q    <= 3'b000;
         off_q       <= '0;
         is_store_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         load_data_q <= load_data_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_wdata_q <= mem_wdata_d;
         wait_q      <= wait_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         is_store_q  <= is_store_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err_code  = err_q;
   assign load_data = load_data_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wstrb = mem_wstrb_q;
   assign mem_wdata = mem_wdata_q;

endmodule
